regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the integer register file: N combinational read ports, one write port, x0 hard-wired to zero.
- Adds asynchronous reset of every register and a per-register busy scoreboard so the decode stage can detect RAW hazards.
- Sits between decode (reads, issue marking) and writeback (write, busy clear).
- Exception suppresses architectural writes; flush clears all in-flight marks.

Parameters:
- XLEN, `MXLEN, data width in bits.
- REG_NUM, 32, number of architectural registers (power of two, 2..32).
- ADDR_W, 5, register address width; must equal $clog2(REG_NUM).
- NUM_RD, 2, number of read ports (1..4).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- exception  in  1  suppresses the writeback register write this cycle.
- flush  in  1  clears all busy bits (pipeline kill).
- r_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- r_data  out  NUM_RD*XLEN  packed read data; port i at bits [i*XLEN +: XLEN].
- r_busy  out  NUM_RD  per-port: addressed register has a pending write.
- reg_write  in  1  writeback write enable.
- w_addr  in  ADDR_W  writeback destination.
- w_data  in  XLEN  writeback data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- busy_vec  out  REG_NUM  full scoreboard; bit 0 is always 0.

Behaviour:
- Reset (RST_N low, asynchronous): all registers = 0, all busy bits = 0. While reset is held, r_data = 0, r_busy = 0 and busy_vec = 0. Deassertion is synchronised externally.
- Write: on a CLK edge with reg_write=1, exception=0 and w_addr≠0, regs[w_addr] <= w_data. With exception=1 the register is unchanged.
- Busy clear: on a CLK edge with reg_write=1 and w_addr≠0, busy[w_addr] <= 0. This happens regardless of exception, because the instruction has left the pipe.
- Busy set: on a CLK edge with iss_valid=1 and iss_rd≠0, busy[iss_rd] <= 1.
- Set and clear of the same register in the same cycle: set wins, because the newer producer is the issuing instruction.
- Flush: flush=1 clears every busy bit at the edge and takes priority over a busy set in the same cycle. A register write in the same cycle still occurs, subject to exception.
- Read: combinational and zero latency.
  - r_data[i] = 0 when r_addr[i]==0, else regs[r_addr[i]].
  - r_busy[i] = busy[r_addr[i]], forced 0 when r_addr[i]==0.
- Address ≥ REG_NUM (when REG_NUM<32): the read returns 0 with busy 0, and writes and issue marks to it are ignored.
- No internal FSM beyond the scoreboard. Total state is REG_NUM*XLEN register bits plus REG_NUM busy bits.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: write-to-read bypass. When reg_write=1, exception=0, w_addr≠0 and w_addr==r_addr[i], then r_data[i]=w_data and r_busy[i]=0 in the same cycle. The same-cycle issue to that address is still honoured at the edge.
- Undefined: reads return the stored value only, so the new value is visible the cycle after the write. r_busy[i] stays 1 during the write cycle.

Decomposition:
- defs.v (shared) provides `MXLEN and a `REG_ZERO 5'd0 constant. Add `REGFILE_MAX_RD 4 for the NUM_RD bound check.
- One sub-module, regfile_sb_scoreboard, holds the busy-vector flops with set/clear/flush priority.
- Parent keeps the data array, read muxes and bypass.

Test Plan:
- Reset then read all 32 addresses on both ports → r_data=0, r_busy=0, busy_vec=0.
- Write x5=0xDEADBEEF (reg_write=1, exception=0), read r_addr0=5 next cycle → 0xDEADBEEF. Write x0=0x1234 → read x0 returns 0.
- Same write with exception=1 and busy[5] preset → x5 keeps its old value; busy[5] cleared.
- iss_valid with iss_rd=7 → busy_vec[7]=1 and r_busy for addr 7 =1. Next cycle writeback w_addr=7 together with iss_rd=7 → busy_vec[7] stays 1. Then flush → busy_vec=0.
- Pull RST_N low mid-stream with x3=0x55 and busy[3]=1 → r_data for addr 3 and busy_vec go to 0 without a clock edge.
- Bypass: write x9=0xA5A5A5A5 while r_addr1=9.
  - REGFILE_SB_BYPASS_EN defined → r_data1=0xA5A5A5A5 in the same cycle.
  - Undefined → old value in that cycle, 0xA5A5A5A5 on the next.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared widths and constants for the scoreboarded register file.
package regfile_sb_pkg;
  localparam int MXLEN = 32;
  localparam int REGFILE_MAX_RD = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits; flush beats set, set beats clear.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [REG_NUM-1:0] busy
);
  logic [REG_NUM-1:0] busy_d;
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < REG_NUM; r++)
      busy_d[r] = flush ? 1'b0 :
                  (set && set_addr == ADDR_W'(r)) ? 1'b1 :
                  (clr && clr_addr == ADDR_W'(r)) ? 1'b0 : busy[r];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy <= '0;
    else busy <= busy_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: N-read/1-write register file with x0 = 0 and a RAW busy scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN    = MXLEN,
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     exception,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*XLEN-1:0]   r_data,
  output logic [NUM_RD-1:0]        r_busy,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [XLEN-1:0]          w_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd,
  output logic [REG_NUM-1:0]       busy_vec
);
  if (ADDR_W != $clog2(REG_NUM) || NUM_RD < 1 || NUM_RD > REGFILE_MAX_RD || REG_NUM < 2) begin : g_bad_param
    $error("regfile_sb: illegal parameter combination");
  end
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [XLEN-1:0] regs [REG_NUM];
  logic wr;
  assign wr = reg_write && !exception && w_addr != ZERO && int'(w_addr) < REG_NUM;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else if (wr) begin
      regs[w_addr] <= w_data;
    end
  end
  regfile_sb_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W)) u_sb (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .flush    (flush),
    .set      (iss_valid),
    .set_addr (iss_rd),
    .clr      (reg_write),
    .clr_addr (w_addr),
    .busy     (busy_vec)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic ok;
    assign a  = r_addr[i*ADDR_W +: ADDR_W];
    assign ok = a != ZERO && int'(a) < REG_NUM;
`ifdef REGFILE_SB_BYPASS_EN
    logic byp;
    assign byp = wr && w_addr == a;
    assign r_data[i*XLEN +: XLEN] = byp ? w_data : ok ? regs[a] : '0;
    assign r_busy[i] = !byp && ok && busy_vec[a];
`else
    assign r_data[i*XLEN +: XLEN] = ok ? regs[a] : '0;
    assign r_busy[i] = ok && busy_vec[a];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus feeding an expectation queue drained by a negedge monitor.
module tb_regfile_sb;
  logic        CLK = 0;
  logic        RST_N, exception, flush, reg_write, iss_valid;
  logic [9:0]  r_addr;
  logic [63:0] r_data;
  logic [1:0]  r_busy;
  logic [4:0]  w_addr, iss_rd;
  logic [31:0] w_data, busy_vec;
  typedef enum int {K_RD, K_RB, K_BV} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  regfile_sb dut (
    .CLK(CLK), .RST_N(RST_N), .exception(exception), .flush(flush),
    .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .reg_write(reg_write), .w_addr(w_addr), .w_data(w_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec)
  );
  always #5 CLK = ~CLK;
  task automatic expect_v(input string name, input kind_t kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.exp = exp;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = e.kind == K_RD ? r_data[e.port*32 +: 32] :
            e.kind == K_RB ? {31'd0, r_busy[e.port]} : busy_vec;
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, got, e.exp);
      end
    end
  end
  initial begin
    RST_N = 0; exception = 0; flush = 0; reg_write = 0; iss_valid = 0;
    r_addr = '0; w_addr = '0; iss_rd = '0; w_data = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    expect_v("reset_busy_vec", K_BV, 0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      r_addr = {5'(a), 5'(a)};
      expect_v("reset_rd", K_RD, 0, 32'h0);
      expect_v("reset_rd", K_RD, 1, 32'h0);
      expect_v("reset_rb", K_RB, 0, 32'h0);
      expect_v("reset_rb", K_RB, 1, 32'h0);
      tick();
    end
    reg_write = 1; w_addr = 5; w_data = 32'hDEADBEEF; r_addr = {5'd0, 5'd0};
    tick();
    w_addr = 0; w_data = 32'h1234; r_addr = {5'd0, 5'd5};
    expect_v("wr_x5", K_RD, 0, 32'hDEADBEEF);
    expect_v("wr_x0_same_cycle", K_RD, 1, 32'h0);
    tick();
    reg_write = 0;
    expect_v("x0_stays_zero", K_RD, 1, 32'h0);
    expect_v("x5_held", K_RD, 0, 32'hDEADBEEF);
    iss_valid = 1; iss_rd = 5;
    tick();
    iss_valid = 0;
    expect_v("iss_x5_vec", K_BV, 0, 32'h0000_0020);
    expect_v("iss_x5_rb", K_RB, 0, 32'h1);
    reg_write = 1; exception = 1; w_addr = 5; w_data = 32'h1111_1111;
    expect_v("exc_no_bypass", K_RD, 0, 32'hDEADBEEF);
    expect_v("exc_rb_still", K_RB, 0, 32'h1);
    tick();
    reg_write = 0; exception = 0;
    expect_v("exc_keeps_x5", K_RD, 0, 32'hDEADBEEF);
    expect_v("exc_clears_busy", K_BV, 0, 32'h0);
    expect_v("exc_clears_rb", K_RB, 0, 32'h0);
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0; r_addr = {5'd7, 5'd7};
    expect_v("iss_x7_vec", K_BV, 0, 32'h0000_0080);
    expect_v("iss_x7_rb", K_RB, 0, 32'h1);
    expect_v("iss_x7_rb", K_RB, 1, 32'h1);
    reg_write = 1; w_addr = 7; w_data = 32'h77; iss_valid = 1; iss_rd = 7;
    tick();
    reg_write = 0; iss_valid = 0;
    expect_v("set_beats_clr", K_BV, 0, 32'h0000_0080);
    expect_v("wr_x7", K_RD, 0, 32'h77);
    iss_valid = 1; iss_rd = 12;
    tick();
    iss_valid = 0;
    expect_v("iss_x12_vec", K_BV, 0, 32'h0000_1080);
    flush = 1; iss_valid = 1; iss_rd = 2; reg_write = 1; w_addr = 4; w_data = 32'h44;
    tick();
    flush = 0; iss_valid = 0; reg_write = 0; r_addr = {5'd4, 5'd2};
    expect_v("flush_beats_set", K_BV, 0, 32'h0);
    expect_v("flush_keeps_write", K_RD, 1, 32'h44);
    reg_write = 1; w_addr = 3; w_data = 32'h55; iss_valid = 1; iss_rd = 3;
    tick();
    reg_write = 0; iss_valid = 0; r_addr = {5'd3, 5'd3};
    expect_v("pre_rst_x3", K_RD, 0, 32'h55);
    expect_v("pre_rst_vec", K_BV, 0, 32'h0000_0008);
    expect_v("pre_rst_rb", K_RB, 1, 32'h1);
    @(posedge CLK);
    #2 RST_N = 0;
    expect_v("async_rst_x3", K_RD, 0, 32'h0);
    expect_v("async_rst_vec", K_BV, 0, 32'h0);
    expect_v("async_rst_rb", K_RB, 1, 32'h0);
    tick();
    RST_N = 1;
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 0;
    reg_write = 1; w_addr = 9; w_data = 32'hA5A5A5A5; r_addr = {5'd9, 5'd0};
`ifdef REGFILE_SB_BYPASS_EN
    expect_v("bypass_rd", K_RD, 1, 32'hA5A5A5A5);
    expect_v("bypass_rb", K_RB, 1, 32'h0);
`else
    expect_v("nobypass_rd", K_RD, 1, 32'h0);
    expect_v("nobypass_rb", K_RB, 1, 32'h1);
`endif
    tick();
    reg_write = 0; r_addr = {5'd9, 5'd3};
    expect_v("after_wr_x9", K_RD, 1, 32'hA5A5A5A5);
    expect_v("after_wr_rb", K_RB, 1, 32'h0);
    expect_v("x3_after_rst", K_RD, 0, 32'h0);
    expect_v("final_vec", K_BV, 0, 32'h0);
    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
